param_divider: RTL and testbench
================================

PARAM_DIVIDER -- requirements
Module: param_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal values are even numbers 8..64.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request; accepted only on an edge where start=1 and busy=0.
REQ-005 SHALL have port kill  input  1  abort of an in-flight operation.
REQ-006 SHALL have port div_op  input  3  operation select: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have port dividend  input  WIDTH  numerator.
REQ-008 SHALL have port divisor  input  WIDTH  denominator.
REQ-009 SHALL have port result  output  WIDTH  registered quotient or remainder.
REQ-010 SHALL have port busy  output  1  operation in flight.
REQ-011 SHALL have port finished  output  1  one-cycle pulse: result valid.

Function
REQ-012 SHALL latch div_op, dividend and divisor at accept; later input changes SHALL NOT affect the operation.
REQ-013 SHALL use FSM states IDLE -> CALC -> FIXUP -> IDLE; accept moves IDLE->CALC and sets busy=1.
REQ-014 CALC SHALL run one restoring shift-subtract step per cycle on WIDTH-bit magnitudes, with a WIDTH+1-bit trial subtract whose MSB gives the sign; exactly WIDTH steps, counter 0..WIDTH-1.
REQ-015 FIXUP SHALL apply sign correction, register result, set finished=1 and busy=0; finished SHALL clear on the next edge.
REQ-016 Latency SHALL be: finished first high WIDTH+2 rising edges after the accept edge.
REQ-017 Signed ops SHALL produce quotient sign = dividend sign XOR divisor sign and remainder sign = dividend sign (truncating division).
REQ-018 divisor=0 SHALL give DIV/DIVU result all-ones and REM/REMU result = dividend.
REQ-019 DIV with dividend=most-negative and divisor=-1 SHALL give the most-negative value; REM SHALL give 0.
REQ-020 Unlisted div_op codes SHALL be accepted, follow normal timing, and return result 0.
REQ-021 result SHALL hold its value until the next FIXUP or rst.
REQ-022 kill=1 SHALL force IDLE, busy=0 and finished=0 on that edge and SHALL leave result unchanged.
REQ-023 start with kill on the same edge SHALL NOT be accepted.
REQ-024 start while busy=1 SHALL be ignored, with no queuing.
REQ-025 start on the edge where finished=1 and busy=0 SHALL be accepted, giving back-to-back operation.

Reset
REQ-026 rst SHALL force state=IDLE, busy=0, finished=0, result=0 and counter=0; it takes precedence over kill and start.
REQ-027 rst mid-operation SHALL discard the operation with no finished pulse.

Configuration
REQ-028 With macro PARAM_DIVIDER_EARLY_OUT_EN defined, these cases SHALL skip CALC (IDLE->FIXUP) and give finished 2 edges after accept:
  - divisor=0
  - signed overflow
  - |dividend| < |divisor|, giving quotient 0 and remainder = dividend
REQ-029 Without the macro, every operation SHALL take the REQ-016 latency with identical results.

Structure
REQ-030 Shared package div_pkg SHALL hold the div_op encodings (DIV, DIVU, REM, REMU) and the FSM state enum.
REQ-031 The combinational single-step restore logic SHALL be sub-module div_step (inputs: partial remainder, quotient, divisor; outputs: next remainder, next quotient).

Verification
REQ-032 WIDTH=32, DIVU 100/7 -> result 14 at edge 34 after accept; REMU 100/7 -> 2.
REQ-033 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF.
REQ-034 DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; REM same operands -> 0. With EARLY_OUT_EN: finished at edge 2; without: edge 34.
REQ-035 kill asserted at CALC step 10 -> busy=0 next cycle, no finished pulse, result unchanged; a new start afterwards completes correctly.
REQ-036 start held high continuously with changing operands -> exactly one accept per operation, back-to-back accepts on finished edges, results match the operands latched at each accept.
REQ-037 WIDTH=8 random signed/unsigned sweep vs reference model -> all results match, latency 10 edges.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared operation encodings and FSM state type for param_divider.
package div_pkg;
  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REM  = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;
  typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_e;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring shift-subtract step on WIDTH-bit magnitudes.
// Ports: rem_i/quo_i/dvs_i partial remainder, quotient shift register, divisor magnitude;
//        rem_o/quo_o next partial remainder and quotient.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);
  logic [WIDTH:0] part, diff;
  assign part  = {rem_i, quo_i[WIDTH-1]};
  // The extra MSB of the trial subtract is its sign: set means restore.
  assign diff  = part - {1'b0, dvs_i};
  assign rem_o = diff[WIDTH] ? part[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_o = {quo_i[WIDTH-2:0], ~diff[WIDTH]};
endmodule

// File: rtl/param_divider.sv
// param_divider: multi-cycle signed/unsigned divider (DIV, DIVU, REM, REMU), truncating.
// Ports: clk, rst (sync, active-high), start/kill control, div_op/dividend/divisor operands,
//        result (registered), busy (operation in flight), finished (one-cycle result-valid pulse).
// Option: define PARAM_DIVIDER_EARLY_OUT_EN to skip CALC for divide-by-zero, signed overflow
//         and |dividend| < |divisor|.
module param_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             kill,
  input  logic [2:0]       div_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             finished
);
  localparam int CW = $clog2(WIDTH);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q, rem_n, quo_n, result_q, res_d;
  logic [WIDTH-1:0] a_mag, b_mag, rem_init, quo_init;
  logic valid_q, isrem_q, qneg_q, rneg_q, dz_q, finished_q;
  logic sgn, a_neg, b_neg, accept, early, last;
  assign sgn      = (div_op == OP_DIV) || (div_op == OP_REM);
  assign a_neg    = sgn & dividend[WIDTH-1];
  assign b_neg    = sgn & divisor[WIDTH-1];
  assign a_mag    = a_neg ? -dividend : dividend;
  assign b_mag    = b_neg ? -divisor : divisor;
  assign busy     = state_q != IDLE;
  assign accept   = start & ~busy & ~kill;
  assign last     = cnt_q == CW'(WIDTH - 1);
  assign result   = result_q;
  assign finished = finished_q;
`ifdef PARAM_DIVIDER_EARLY_OUT_EN
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  logic ovf;
  assign ovf      = sgn && dividend == MIN && divisor == '1;
  assign early    = div_op[2] && (divisor == '0 || ovf || a_mag < b_mag);
  // Preload the registers with the answer CALC would have produced.
  assign rem_init = (early && !ovf) ? a_mag : '0;
  assign quo_init = ovf ? MIN : early ? '0 : a_mag;
`else
  assign early    = 1'b0;
  assign rem_init = '0;
  assign quo_init = a_mag;
`endif
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i(rem_q),
    .quo_i(quo_q),
    .dvs_i(dvs_q),
    .rem_o(rem_n),
    .quo_o(quo_n)
  );
  always_comb begin
    state_d = state_q;
    if (kill) state_d = IDLE;
    else if (accept) state_d = early ? FIXUP : CALC;
    else if (state_q == CALC) state_d = last ? FIXUP : CALC;
    else if (state_q == FIXUP) state_d = IDLE;
  end
  // Divide-by-zero quotient is forced; the remainder path already yields the dividend.
  assign res_d = !valid_q ? '0 :
                 isrem_q  ? (rneg_q ? -rem_q : rem_q) :
                 dz_q     ? '1 : (qneg_q ? -quo_q : quo_q);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      result_q   <= '0;
      finished_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      finished_q <= !kill && state_q == FIXUP;
      if (accept) begin
        valid_q <= div_op[2];
        isrem_q <= div_op[1];
        qneg_q  <= a_neg ^ b_neg;
        rneg_q  <= a_neg;
        dz_q    <= divisor == '0;
        dvs_q   <= b_mag;
        rem_q   <= rem_init;
        quo_q   <= quo_init;
        cnt_q   <= '0;
      end else if (state_q == CALC) begin
        rem_q <= rem_n;
        quo_q <= quo_n;
        cnt_q <= last ? '0 : cnt_q + CW'(1);
      end
      if (!kill && state_q == FIXUP) result_q <= res_d;
    end
  end
endmodule

// File: tb/tb_param_divider.sv
// tb_param_divider: randomized scoreboard bench for param_divider against a behavioural model.
module tb_param_divider;
  localparam int W = 32;
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
`ifdef PARAM_DIVIDER_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, kill = 1'b0;
  logic [2:0] div_op = 3'b100;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic [W-1:0] result;
  logic busy, finished;

  param_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .kill(kill), .div_op(div_op),
    .dividend(dividend), .divisor(divisor), .result(result), .busy(busy), .finished(finished)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_res(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W-1:0] sa, sb, q;
    sa = a;
    sb = b;
    q  = '0;
    if (op == 3'b100 || op == 3'b110) begin
      if (b == '0) return (op == 3'b100) ? '1 : a;
      if (a == MIN && b == '1) return (op == 3'b100) ? MIN : '0;
      q = (op == 3'b100) ? sa / sb : sa % sb;
      return q;
    end
    if (op == 3'b101) return (b == '0) ? '1 : a / b;
    if (op == 3'b111) return (b == '0) ? a : a % b;
    return '0;
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic sg, e;
    logic [W-1:0] ma, mb;
    sg = op == 3'b100 || op == 3'b110;
    ma = (sg && a[W-1]) ? -a : a;
    mb = (sg && b[W-1]) ? -b : b;
    e  = op[2] && (b == '0 || (sg && a == MIN && b == '1) || ma < mb);
    return (EARLY && e) ? 2 : W + 2;
  endfunction

  typedef struct {int id; logic [W-1:0] res;} sb_t;
  sb_t sb[$];
  bit active = 1'b0, fin_now = 1'b0;
  int k = 0, cur_lat = 0, cur_id = 0, next_id = 0, done_id = -1;
  logic [W-1:0] cur_res = '0, exp_hold = '0;

  // Reference model: tracks the accepted operation and when its result is due.
  always @(posedge clk) begin
    fin_now = 1'b0;
    if (rst) begin
      active   = 1'b0;
      exp_hold = '0;
    end else if (kill) begin
      active = 1'b0;
    end else if (active) begin
      k++;
      if (k == cur_lat - 1) begin
        active   = 1'b0;
        fin_now  = 1'b1;
        exp_hold = cur_res;
        done_id  = cur_id;
      end
    end else if (start) begin
      cur_res = ref_res(div_op, dividend, divisor);
      cur_lat = ref_lat(div_op, dividend, divisor);
      cur_id  = next_id++;
      k       = 0;
      active  = 1'b1;
      sb.push_back('{cur_id, cur_res});
    end
  end

  int n_vec = 0, n_err = 0, rd = 0;

  // Monitor: compares DUT outputs away from the active edge.
  always @(negedge clk) begin
    n_vec++;
    if (finished !== fin_now) begin
      n_err++;
      $display("FAIL finished: got %b want %b at %0t", finished, fin_now, $time);
    end
    n_vec++;
    if (busy !== active) begin
      n_err++;
      $display("FAIL busy: got %b want %b at %0t", busy, active, $time);
    end
    n_vec++;
    if (fin_now) begin
      while (rd < sb.size() && sb[rd].id != done_id) rd++;
      if (rd >= sb.size()) begin
        n_err++;
        $display("FAIL scoreboard: no entry for op %0d, result %h at %0t", done_id, result, $time);
      end else begin
        if (result !== sb[rd].res) begin
          n_err++;
          $display("FAIL result op %0d: got %h want %h at %0t", done_id, result, sb[rd].res, $time);
        end
        rd++;
      end
    end else if (result !== exp_hold) begin
      n_err++;
      $display("FAIL hold: got %h want %h at %0t", result, exp_hold, $time);
    end
  end

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return MIN;
      3: return W'($urandom_range(0, 20));
      4: return -W'($urandom_range(1, 20));
      default: return W'($urandom);
    endcase
  endfunction

  task automatic wait_idle();
    int g = 0;
    while (active && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) begin
      $display("FAIL wait_idle: still busy after %0d cycles", g);
      $fatal(1);
    end
  endtask

  task automatic run(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int kill_at);
    wait_idle();
    @(negedge clk);
    div_op = op; dividend = a; divisor = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; div_op = 3'($urandom); dividend = pick(); divisor = pick();
    if (kill_at >= 0) begin
      repeat (kill_at) @(negedge clk);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
    end
    wait_idle();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run(3'b101, 100, 7, -1);
    run(3'b111, 100, 7, -1);
    run(3'b100, -32'sd7, 2, -1);
    run(3'b110, -32'sd7, 2, -1);
    run(3'b101, '1, 1, -1);
    run(3'b100, 5, 0, -1);
    run(3'b110, 5, 0, -1);
    run(3'b100, -32'sd9, 0, -1);
    run(3'b100, MIN, '1, -1);
    run(3'b110, MIN, '1, -1);
    run(3'b111, 5, 9, -1);
    run(3'b110, -32'sd5, 9, -1);
    run(3'b011, 100, 7, -1);
    run(3'b100, 1000, 3, 9);
    run(3'b101, 1000, 3, -1);
    // Reset in the middle of an operation.
    @(negedge clk);
    div_op = 3'b101; dividend = 77; divisor = 5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    // Start together with kill is not accepted.
    @(negedge clk);
    div_op = 3'b101; dividend = 50; divisor = 3; start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    run(3'b110, 50, 3, -1);
    // Start held high: back-to-back accepts with operands changing every cycle.
    @(negedge clk);
    start = 1'b1;
    repeat (5 * (W + 2)) begin
      div_op = {1'b1, 2'($urandom_range(0, 3))}; dividend = pick(); divisor = pick();
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();
    for (int i = 0; i < 120; i++)
      run(($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 3)) : {1'b1, 2'($urandom_range(0, 3))},
          pick(), pick(), ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, W + 3)) : -1);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
